// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared constants and state type for the counter sequencer
package counter_seq_pkg;

  localparam int COUNTER_SEQ_WIDTH = 3;
  localparam int COUNTER_SEQ_NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/counter_datapath.sv
// rtl/counter_datapath.sv - shared up-counter register with clear and step enable
module counter_datapath
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = COUNTER_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Clear wins over step so a fresh grant always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - round-robin sequencer sharing one counter between two requesters
// Optional pause input enabled by COUNTER_SEQ_PAUSE_EN.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = COUNTER_SEQ_WIDTH,
  parameter int NREQ  = COUNTER_SEQ_NREQ
) (
  input  logic                  input_clock1_1,
  input  logic                  input_reset1_2,
`ifdef COUNTER_SEQ_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_limit,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count,
  output logic                  busy
);

  seq_state_t       state_d, state_q;
  logic [NREQ-1:0]  grant_d, grant_q;
  logic [NREQ-1:0]  done_d, done_q;
  logic             busy_d, busy_q;
  logic             ptr_d, ptr_q;
  logic             winner_d, winner_q;
  logic [WIDTH-1:0] limit_d, limit_q;
  logic             clr;
  logic             en;
  logic             pause_w;

`ifdef COUNTER_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  counter_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (input_clock1_1),
    .rst   (input_reset1_2),
    .clr   (clr),
    .en    (en),
    .count (count)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    limit_d  = limit_q;
    clr      = 1'b0;
    en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          winner_d          = (req[0] && req[1]) ? ptr_q : req[1];
          limit_d           = winner_d ? req_limit[WIDTH +: WIDTH] : req_limit[0 +: WIDTH];
          clr               = 1'b1;
          grant_d           = '0;
          grant_d[winner_d] = 1'b1;
          busy_d            = 1'b1;
          state_d           = RUN;
        end
      end
      RUN: begin
        // Abort outranks both pause and the terminal check.
        if (!req[winner_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ~winner_q;
          state_d = IDLE;
        end else if (!pause_w) begin
          if (count == limit_q) begin
            grant_d          = '0;
            busy_d           = 1'b0;
            done_d[winner_q] = 1'b1;
            ptr_d            = ~winner_q;
            state_d          = DONE;
          end else begin
            en = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= 1'b0;
      winner_q <= 1'b0;
      limit_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      limit_q  <= limit_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer
module tb_counter_sequencer;

  localparam int W = 3;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] vec;
    int         cnt;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req;
  logic [2*W-1:0] req_limit;
  logic [1:0]     grant;
  logic [1:0]     done;
  logic [W-1:0]   count;
  logic           busy;
`ifdef COUNTER_SEQ_PAUSE_EN
  logic           pause;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   ptr_m = 0;
  logic [1:0] prev_grant = 2'b00;
  ev_t  exp_q[$];

  counter_sequencer dut (
    .input_clock1_1 (clk),
    .input_reset1_2 (rst),
`ifdef COUNTER_SEQ_PAUSE_EN
    .pause          (pause),
`endif
    .req            (req),
    .req_limit      (req_limit),
    .grant          (grant),
    .done           (done),
    .count          (count),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int kind, input int c, input int idx, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.vec  = (idx == 1) ? 2'b10 : 2'b01;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endfunction

  task automatic check_event(input int kind, input logic [1:0] vec);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind=%0d cyc=%0d vec=%b cnt=%0d", kind, cyc, vec, count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.vec != vec || e.cnt != int'(count)) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d vec=%b cnt=%0d, expected kind=%0d cyc=%0d vec=%b cnt=%0d",
                 kind, cyc, vec, count, e.kind, e.cyc, e.vec, e.cnt);
      end
    end
  endtask

  // Monitor: classifies each output change as grant start, done pulse or abort.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== (grant != 2'b00)) begin
        errors++;
        $display("FAIL busy: got %b expected %b at cyc %0d", busy, (grant != 2'b00), cyc);
      end
      if (done != 2'b00)                              check_event(EV_DONE, done);
      else if (prev_grant == 2'b00 && grant != 2'b00) check_event(EV_GRANT, grant);
      else if (prev_grant != 2'b00 && grant == 2'b00) check_event(EV_ABORT, prev_grant);
      prev_grant = grant;
    end
  end

  task automatic check_zero(input string tag);
    checks += 4;
    if (grant !== 2'b00) begin errors++; $display("FAIL %s grant: got %b expected 00", tag, grant); end
    if (done  !== 2'b00) begin errors++; $display("FAIL %s done: got %b expected 00", tag, done); end
    if (count !== 3'd0)  begin errors++; $display("FAIL %s count: got %0d expected 0", tag, count); end
    if (busy  !== 1'b0)  begin errors++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
  endtask

  // One arbitration round from IDLE; ab = cycles into the run at which the requester drops (-1: none).
  task automatic scenario(input logic [1:0] pat, input int lim0, input int lim1,
                          input int ab0, input int ab1, input int pz_off, input int pz_len);
    int lim[2];
    int ab[2];
    int drop[2];
    int k, k0, first, nsvc, last, pstart;
    lim[0] = lim0; lim[1] = lim1;
    ab[0] = ab0;   ab[1] = ab1;
    drop[0] = -1;  drop[1] = -1;
    k = cyc;
    k0 = k;
    last = k;
    req_limit = {W'(lim1), W'(lim0)};
    req = pat;
    first = (pat == 2'b11) ? ptr_m : (pat[1] ? 1 : 0);
    nsvc = (pat == 2'b11) ? 2 : 1;
    pstart = k + 1 + pz_off;
    for (int s = 0; s < nsvc; s++) begin
      int w;
      int pl;
      w  = (s == 0) ? first : 1 - first;
      pl = (s == 0) ? pz_len : 0;
      push(EV_GRANT, k + 1, w, 0);
      if (ab[w] >= 0) begin
        drop[w] = k + 1 + ab[w];
        last = drop[w] + 1;
        push(EV_ABORT, last, w, ab[w]);
      end else begin
        last = k + 2 + lim[w] + pl;
        push(EV_DONE, last, w, lim[w]);
        drop[w] = last + 1;
      end
      k = last;
      if (ab[w] < 0) k = last + 1;
      ptr_m = 1 - w;
    end
    while (cyc <= last + 1) begin
      step();
      for (int i = 0; i < 2; i++) if (cyc == drop[i]) req[i] = 1'b0;
      if (cyc == k0 + 2) req_limit[first*W +: W] = W'($urandom);
`ifdef COUNTER_SEQ_PAUSE_EN
      pause = (pz_len > 0) && (cyc >= pstart) && (cyc < pstart + pz_len);
`endif
    end
    req = 2'b00;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    req = 2'b00;
    req_limit = '0;
`ifdef COUNTER_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
    check_zero("reset");
    mon_en = 1'b1;

    scenario(2'b11, 2, 3, -1, -1, 0, 0);
    scenario(2'b01, 5, 0, -1, -1, 0, 0);
    scenario(2'b10, 0, 0, -1, -1, 0, 0);
    scenario(2'b01, 7, 0, -1, -1, 0, 0);
    scenario(2'b01, 6, 0, 2, -1, 0, 0);
`ifdef COUNTER_SEQ_PAUSE_EN
    scenario(2'b01, 4, 0, -1, -1, 1, 3);
    scenario(2'b10, 0, 0, -1, -1, 0, 0);
`endif

    // Pointer favours req1 here; a mid-run reset must restore req0 priority.
    k = cyc;
    req_limit = {3'd0, 3'd6};
    req = 2'b01;
    push(EV_GRANT, k + 1, 0, 0);
    push(EV_ABORT, k + 4, 0, 0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 2'b00;
    check_zero("midrun_reset");
    ptr_m = 0;
    step();
    scenario(2'b11, 1, 4, -1, -1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] pat;
      int l0, l1, a0, a1, po, pl;
      pat = 2'($urandom_range(1, 3));
      l0 = int'($urandom_range(0, 7));
      l1 = int'($urandom_range(0, 7));
      a0 = (l0 > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, l0 - 1)) : -1;
      a1 = (l1 > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, l1 - 1)) : -1;
      po = 0;
      pl = 0;
`ifdef COUNTER_SEQ_PAUSE_EN
      if (a0 < 0 && a1 < 0 && $urandom_range(0, 2) == 0) begin
        pl = int'($urandom_range(1, 3));
        po = int'($urandom_range(0, (l0 < l1) ? l0 : l1));
      end
`endif
      scenario(pat, l0, l1, a0, a1, po, pl);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d events never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
